// File: rtl/alu_rs_if.sv
// Dispatch, CDB and issue signals between the decoder, the ALU reservation
// station and the ALU execute unit.
interface alu_rs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6
);
  localparam int unsigned ROB_W = TAG_W - 1;
  localparam int unsigned PKT_W = ROB_W + 2 * (TAG_W + DATA_W) + OP_W;

  logic              aluEnable;
  logic [PKT_W-1:0]  aluData;
  logic              rsFull;
  logic              flush;
  logic              cdbEnable;
  logic [ROB_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;
  logic              issueEnable;
  logic [OP_W-1:0]   issueOp;
  logic [DATA_W-1:0] issueData1;
  logic [DATA_W-1:0] issueData2;
  logic [ROB_W-1:0]  issueDest;

  // Decoder/CDB/ALU side
  modport master (
    output aluEnable, aluData, flush, cdbEnable, cdbTag, cdbData,
    input  rsFull, issueEnable, issueOp, issueData1, issueData2, issueDest
  );

  // Reservation station side
  modport slave (
    input  aluEnable, aluData, flush, cdbEnable, cdbTag, cdbData,
    output rsFull, issueEnable, issueOp, issueData1, issueData2, issueDest
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// available (captured at dispatch or snooped from the CDB), then issues the
// lowest-index ready entry, one per cycle.
module alu_reservation_station #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave rs
);
  localparam int unsigned ROB_W = TAG_W - 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ROB_W-1:0]  dest;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] data2;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] data1;
    logic [OP_W-1:0]   op;
  } pkt_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  dest;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] data1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] data2;
  } entry_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  entry_t            entry_q [DEPTH];
  entry_t            entry_d [DEPTH];
  logic              issue_en_q, issue_en_d;
  logic [OP_W-1:0]   issue_op_q, issue_op_d;
  logic [DATA_W-1:0] issue_data1_q, issue_data1_d;
  logic [DATA_W-1:0] issue_data2_q, issue_data2_d;
  logic [ROB_W-1:0]  issue_dest_q, issue_dest_d;

  logic [CNT_W-1:0]  count_c;
  logic              rs_full_c;
  logic              free_found_c;
  logic [IDX_W-1:0]  free_idx_c;
  logic              ready_found_c;
  logic [IDX_W-1:0]  ready_idx_c;
  pkt_t              pkt_c;
  entry_t            new_entry_c;

  assign pkt_c = pkt_t'(rs.aluData);

  // Occupancy count plus lowest free slot and lowest ready slot, all from stored state
  always_comb begin
    count_c       = '0;
    free_found_c  = 1'b0;
    free_idx_c    = '0;
    ready_found_c = 1'b0;
    ready_idx_c   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_c = count_c + CNT_W'(valid_q[i]);
      if (!valid_q[i] && !free_found_c) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
      if (valid_q[i] && entry_q[i].tag1[TAG_W-1] && entry_q[i].tag2[TAG_W-1]
          && !ready_found_c) begin
        ready_found_c = 1'b1;
        ready_idx_c   = IDX_W'(i);
      end
    end
    rs_full_c = (count_c == CNT_W'(DEPTH));
  end

  assign rs.rsFull = rs_full_c;

  // Incoming entry, with same-edge CDB results forwarded into pending operands
  always_comb begin
    new_entry_c.op    = pkt_c.op;
    new_entry_c.dest  = pkt_c.dest;
    new_entry_c.tag1  = pkt_c.tag1;
    new_entry_c.data1 = pkt_c.data1;
    new_entry_c.tag2  = pkt_c.tag2;
    new_entry_c.data2 = pkt_c.data2;
    if (rs.cdbEnable && !pkt_c.tag1[TAG_W-1] && (pkt_c.tag1[ROB_W-1:0] == rs.cdbTag)) begin
      new_entry_c.data1           = rs.cdbData;
      new_entry_c.tag1[TAG_W-1]   = 1'b1;
    end
    if (rs.cdbEnable && !pkt_c.tag2[TAG_W-1] && (pkt_c.tag2[ROB_W-1:0] == rs.cdbTag)) begin
      new_entry_c.data2           = rs.cdbData;
      new_entry_c.tag2[TAG_W-1]   = 1'b1;
    end
  end

  // Next state: flush wins; otherwise issue, CDB wakeup and allocation in parallel
  always_comb begin
    valid_d       = valid_q;
    entry_d       = entry_q;
    issue_en_d    = 1'b0;
    issue_op_d    = issue_op_q;
    issue_data1_d = issue_data1_q;
    issue_data2_d = issue_data2_q;
    issue_dest_d  = issue_dest_q;
    if (rs.flush) begin
      valid_d = '0;
    end else begin
      if (ready_found_c) begin
        issue_en_d             = 1'b1;
        issue_op_d             = entry_q[ready_idx_c].op;
        issue_data1_d          = entry_q[ready_idx_c].data1;
        issue_data2_d          = entry_q[ready_idx_c].data2;
        issue_dest_d           = entry_q[ready_idx_c].dest;
        valid_d[ready_idx_c]   = 1'b0;
      end
      if (rs.cdbEnable) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (valid_q[i] && !entry_q[i].tag1[TAG_W-1]
              && (entry_q[i].tag1[ROB_W-1:0] == rs.cdbTag)) begin
            entry_d[i].data1         = rs.cdbData;
            entry_d[i].tag1[TAG_W-1] = 1'b1;
          end
          if (valid_q[i] && !entry_q[i].tag2[TAG_W-1]
              && (entry_q[i].tag2[ROB_W-1:0] == rs.cdbTag)) begin
            entry_d[i].data2         = rs.cdbData;
            entry_d[i].tag2[TAG_W-1] = 1'b1;
          end
        end
      end
      if (rs.aluEnable && !rs_full_c && free_found_c) begin
        entry_d[free_idx_c] = new_entry_c;
        valid_d[free_idx_c] = 1'b1;
      end
    end
  end

  // State and issue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      entry_q       <= '{default: '0};
      issue_en_q    <= 1'b0;
      issue_op_q    <= '0;
      issue_data1_q <= '0;
      issue_data2_q <= '0;
      issue_dest_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      entry_q       <= entry_d;
      issue_en_q    <= issue_en_d;
      issue_op_q    <= issue_op_d;
      issue_data1_q <= issue_data1_d;
      issue_data2_q <= issue_data2_d;
      issue_dest_q  <= issue_dest_d;
    end
  end

  assign rs.issueEnable = issue_en_q;
  assign rs.issueOp     = issue_op_q;
  assign rs.issueData1  = issue_data1_q;
  assign rs.issueData2  = issue_data2_q;
  assign rs.issueDest   = issue_dest_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for the ALU reservation station with an issue scoreboard.
module tb_alu_reservation_station;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned PKT_W  = (TAG_W - 1) + 2 * (TAG_W + DATA_W) + OP_W;
  localparam logic [3:0]  FREE   = 4'b1000;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  dest;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_rs_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

  alu_reservation_station #(.DEPTH(8), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] pkt(input logic [2:0] dest, input logic [3:0] t2,
                                           input logic [31:0] d2, input logic [3:0] t1,
                                           input logic [31:0] d1, input logic [5:0] op);
    return {dest, t2, d2, t1, d1, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [2:0] dest);
    exp_t e;
    e.op = op; e.d1 = d1; e.d2 = d2; e.dest = dest;
    exp_q.push_back(e);
  endtask

  // One clock; sample #1 after the edge and score any issue against the queue
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.issueEnable === 1'b1) begin
      chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_op", 64'(bus.issueOp), 64'(e.op));
        chk("issue_d1", 64'(bus.issueData1), 64'(e.d1));
        chk("issue_d2", 64'(bus.issueData2), 64'(e.d2));
        chk("issue_dest", 64'(bus.issueDest), 64'(e.dest));
      end
    end
  endtask

  initial begin
    bus.aluEnable = 1'b0;
    bus.aluData   = '0;
    bus.flush     = 1'b0;
    bus.cdbEnable = 1'b0;
    bus.cdbTag    = '0;
    bus.cdbData   = '0;
    #12 rst = 1'b0;
    #1;
    chk("rst_issue_en", 64'(bus.issueEnable), 64'd0);
    chk("rst_issue_op", 64'(bus.issueOp), 64'd0);
    chk("rst_issue_d1", 64'(bus.issueData1), 64'd0);
    chk("rst_issue_d2", 64'(bus.issueData2), 64'd0);
    chk("rst_issue_dest", 64'(bus.issueDest), 64'd0);
    chk("rst_full", 64'(bus.rsFull), 64'd0);
    tick();

    // ADD with both operands ready at dispatch
    bus.aluEnable = 1'b1;
    bus.aluData   = pkt(3'd3, FREE, 32'd7, FREE, 32'd5, 6'd1);
    push(6'd1, 32'd5, 32'd7, 3'd3);
    tick();
    bus.aluEnable = 1'b0;
    chk("add_not_yet", 64'(bus.issueEnable), 64'd0);
    chk("add_full", 64'(bus.rsFull), 64'd0);
    tick();
    chk("add_issue", 64'(bus.issueEnable), 64'd1);
    chk("add_full2", 64'(bus.rsFull), 64'd0);
    tick();
    chk("add_done", 64'(bus.issueEnable), 64'd0);

    // RR waiting on ROB 2, woken by the CDB three cycles later
    bus.aluEnable = 1'b1;
    bus.aluData   = pkt(3'd4, FREE, 32'd9, 4'b0010, 32'hDEAD, 6'd2);
    tick();
    bus.aluEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_wait", 64'(bus.issueEnable), 64'd0);
    end
    bus.cdbEnable = 1'b1;
    bus.cdbTag    = 3'd2;
    bus.cdbData   = 32'h11;
    push(6'd2, 32'h11, 32'd9, 3'd4);
    tick();
    bus.cdbEnable = 1'b0;
    chk("rr_wake_edge", 64'(bus.issueEnable), 64'd0);
    tick();
    chk("rr_issue", 64'(bus.issueEnable), 64'd1);

    // Dispatch on the same edge as the producing CDB broadcast
    bus.aluEnable = 1'b1;
    bus.aluData   = pkt(3'd5, FREE, 32'd1, 4'b0101, 32'h0, 6'd3);
    bus.cdbEnable = 1'b1;
    bus.cdbTag    = 3'd5;
    bus.cdbData   = 32'hAB;
    push(6'd3, 32'hAB, 32'd1, 3'd5);
    tick();
    bus.aluEnable = 1'b0;
    bus.cdbEnable = 1'b0;
    chk("fwd_not_yet", 64'(bus.issueEnable), 64'd0);
    tick();
    chk("fwd_issue", 64'(bus.issueEnable), 64'd1);

    // Fill all 8 entries waiting on ROB 1
    for (int i = 0; i < 8; i++) begin
      bus.aluEnable = 1'b1;
      bus.aluData   = pkt(3'(i), FREE, 32'(100 + i), 4'b0001, 32'h0, 6'(8 + i));
      tick();
    end
    bus.aluEnable = 1'b0;
    chk("fill_full", 64'(bus.rsFull), 64'd1);
    chk("fill_no_issue", 64'(bus.issueEnable), 64'd0);
    bus.aluEnable = 1'b1;
    bus.aluData   = pkt(3'd7, FREE, 32'h99, FREE, 32'h98, 6'h3F);
    tick();
    bus.aluEnable = 1'b0;
    chk("ninth_full", 64'(bus.rsFull), 64'd1);
    bus.cdbEnable = 1'b1;
    bus.cdbTag    = 3'd1;
    bus.cdbData   = 32'h55;
    for (int i = 0; i < 8; i++) push(6'(8 + i), 32'h55, 32'(100 + i), 3'(i));
    tick();
    bus.cdbEnable = 1'b0;
    chk("wake_still_full", 64'(bus.rsFull), 64'd1);
    tick();
    chk("first_issue", 64'(bus.issueEnable), 64'd1);
    chk("full_dropped", 64'(bus.rsFull), 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("burst_issue", 64'(bus.issueEnable), 64'd1);
    end
    tick();
    chk("burst_done", 64'(bus.issueEnable), 64'd0);
    chk("burst_queue", 64'(exp_q.size()), 64'd0);

    // Three held entries squashed by a flush with competing dispatch and CDB
    for (int i = 0; i < 3; i++) begin
      bus.aluEnable = 1'b1;
      bus.aluData   = pkt(3'(i), FREE, 32'h0, 4'b0110, 32'h0, 6'd4);
      tick();
    end
    bus.aluData   = pkt(3'd6, FREE, 32'h1, FREE, 32'h2, 6'd5);
    bus.flush     = 1'b1;
    bus.cdbEnable = 1'b1;
    bus.cdbTag    = 3'd6;
    bus.cdbData   = 32'h77;
    tick();
    bus.aluEnable = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_issue", 64'(bus.issueEnable), 64'd0);
    chk("flush_full", 64'(bus.rsFull), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) tick();
    bus.cdbEnable = 1'b0;
    chk("flush_quiet", 64'(bus.issueEnable), 64'd0);

    // Asynchronous reset while an issue is being presented
    bus.aluEnable = 1'b1;
    bus.aluData   = pkt(3'd1, FREE, 32'h22, FREE, 32'h21, 6'd6);
    push(6'd6, 32'h21, 32'h22, 3'd1);
    tick();
    bus.aluData   = pkt(3'd2, FREE, 32'h0, 4'b0111, 32'h0, 6'd7);
    tick();
    bus.aluEnable = 1'b0;
    chk("pre_rst_issue", 64'(bus.issueEnable), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en", 64'(bus.issueEnable), 64'd0);
    chk("async_rst_d1", 64'(bus.issueData1), 64'd0);
    chk("async_rst_dest", 64'(bus.issueDest), 64'd0);
    #1 rst = 1'b0;
    bus.cdbEnable = 1'b1;
    bus.cdbTag    = 3'd7;
    bus.cdbData   = 32'h33;
    tick();
    bus.cdbEnable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_quiet", 64'(bus.issueEnable), 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Buffers ALU-class operations dispatched by the decoder (RI, RR, LUI, AUIPC, JAL, JALR) until both operands are valid.
- Snoops the common data bus (CDB) to capture results for pending operand tags.
- Issues at most one ready operation per cycle to the ALU execute unit.
- Sits directly downstream of the decoder and upstream of the ALU.

Parameters:
- DEPTH, 8, number of entries (power of two, at least 2).
- DATA_W, 32, operand width.
- TAG_W, 4, tag width. MSB=1 means free/ready. The low TAG_W-1 bits are the ROB index.
- OP_W, 6, internal opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- aluEnable  in  1  decoder dispatch strobe.
- aluData  in  (TAG_W-1)+2*(TAG_W+DATA_W)+OP_W  packed {dest, tag2, data2, tag1, data1, op}, MSB first.
- rsFull  out  1  no free entry; the decoder stalls dispatch.
- flush  in  1  misprediction squash.
- cdbEnable  in  1  CDB result valid.
- cdbTag  in  TAG_W-1  ROB index of the result.
- cdbData  in  DATA_W  result value.
- issueEnable  out  1  issue valid to the ALU.
- issueOp  out  OP_W  opcode.
- issueData1  out  DATA_W  operand 1.
- issueData2  out  DATA_W  operand 2.
- issueDest  out  TAG_W-1  destination ROB index.

Behaviour:
- Decisions already fixed: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all entry valid bits 0. issueEnable 0. issueOp, issueData1, issueData2 and issueDest all 0. rsFull 0.
- Entry state: valid, op, dest, tag1, data1, tag2, data2.
  - An operand is ready when its tag MSB is 1.
  - An entry is ready when valid and both operands are ready.
- rsFull is combinational from registered state: it equals (count of valid entries == DEPTH).
- Allocation, on a rising edge with aluEnable=1, rsFull=0 and flush=0:
  - Write the lowest-index invalid entry.
  - CDB forwarding at insert: if cdbEnable=1 and an incoming tag is not ready and its low bits equal cdbTag, store cdbData and set that tag to free.
  - If aluEnable=1 while rsFull=1, the request is ignored and no state changes.
- Wakeup, each edge with cdbEnable=1:
  - Every valid entry whose pending tag matches cdbTag captures cdbData and marks that operand ready.
  - Both operands of one entry may wake on the same edge.
- Issue select:
  - Combinational over the stored state: the lowest-index ready entry.
  - An entry woken or allocated on the current edge is not eligible until the next edge.
- Issue registering:
  - On the edge, if a ready entry exists, register its fields onto the issue outputs, set issueEnable=1 and clear the entry's valid bit.
  - Otherwise issueEnable=0 and the other issue outputs hold their previous values.
- Latency:
  - Operands ready at dispatch: issueEnable is high in the cycle after the second rising edge following aluEnable.
  - Operand woken by the CDB: issue follows one edge after the wakeup edge.
- Simultaneous issue and allocation:
  - Both are allowed on the same edge.
  - The freed slot becomes available for allocation only on the following edge, because rsFull is evaluated from pre-edge state.
- Flush is synchronous and takes priority over everything:
  - Clears all valid bits and issueEnable.
  - Ignores aluEnable and the CDB on that edge.
- Asserting reset mid-operation immediately clears all state to the reset values, regardless of the clock.
- There is no ordering requirement between entries; the ROB restores program order.

Test Plan:
- Reset, then dispatch ADD: op=ADD, tag1=tag2=free, data1=5, data2=7, dest=3. Expected: issueEnable=1 in the cycle after the second edge, with issueData1=5, issueData2=7, issueDest=3. rsFull stays 0.
- Dispatch RR with tag1=0_010 pending, data2=9, then a CDB broadcast three cycles later with cdbTag=2, cdbData=0x11. Expected: no issue before the CDB; issue one edge after the CDB edge with issueData1=0x11, issueData2=9.
- Dispatch with pending tag=5 on the same edge as a CDB broadcast with cdbTag=5, cdbData=0xAB. Expected: the value is forwarded at insert; issue one edge later with issueData1=0xAB.
- Dispatch 8 entries, all with operand 1 pending tag 1. Expected: rsFull=1 and a 9th aluEnable is ignored. CDB tag=1 then issues entries 0..7 on consecutive cycles in index order. rsFull drops after the first issue edge.
- Fill 3 entries, then assert flush together with aluEnable and a matching CDB. Expected: all entries invalid, issueEnable=0 on the next cycle, and no later issue.
- Assert rst asynchronously between clock edges while issueEnable=1. Expected: issueEnable=0 immediately, and the held entries never issue.
